// File: rtl/act_quant_pipeline_mlane.sv
// rtl/act_quant_pipeline_mlane.sv - multi-lane activation / normalize / quantize pipeline
//
// Three registered stages, each with its own valid bit and valid/ready flow control:
//   S1 activation (mode, leaky shift and clip are taken with the beat)
//   S2 fixed-point affine normalization with round-half-up shift and ACC_W saturation
//   S3 affine INT quantization with OUT_W saturation and per-lane clip flags
//
// Optional feature macro: ACT_QUANT_SAT_CNT_EN (saturated-lane counter on sat_count).
//
// Ports:
//   clk, reset                   clock, asynchronous active-high reset
//   in_valid / in_ready / acc_in input beat handshake, LANES signed ACC_W words (lane0 in LSBs)
//   act_mode, leaky_shift, act_clip   per-beat activation controls
//   norm_gain, norm_bias, norm_shift  quasi-static normalization controls
//   q_inv_scale, q_zero_point         quasi-static quantization controls (1/S in Q8.8)
//   out_valid / out_ready / ub_data_out   output beat handshake, LANES packed OUT_W results
//   busy                         any stage holds a beat
//   sat_clr, sat_count           saturated-lane counter clear / value

module act_quant_pipeline_mlane #(
    parameter int LANES = 4,
    parameter int ACC_W = 32,
    parameter int OUT_W = 8,
    parameter int CNT_W = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [LANES*ACC_W-1:0]    acc_in,
    input  logic [1:0]                act_mode,
    input  logic [2:0]                leaky_shift,
    input  logic signed [ACC_W-1:0]   act_clip,
    input  logic signed [15:0]        norm_gain,
    input  logic signed [31:0]        norm_bias,
    input  logic [4:0]                norm_shift,
    input  logic signed [15:0]        q_inv_scale,
    input  logic signed [OUT_W-1:0]   q_zero_point,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [LANES*OUT_W-1:0]    ub_data_out,
    output logic                      busy,
    input  logic                      sat_clr,
    output logic [CNT_W-1:0]          sat_count
);

    // Wide enough that gain/bias/rounding and scale/offset/zero-point never wrap.
    localparam int PW = ACC_W + 17;

    localparam logic signed [PW-1:0] ACC_MAX = {{(PW-ACC_W+1){1'b0}}, {(ACC_W-1){1'b1}}};
    localparam logic signed [PW-1:0] ACC_MIN = {{(PW-ACC_W+1){1'b1}}, {(ACC_W-1){1'b0}}};
    localparam logic signed [PW-1:0] OUT_MAX = {{(PW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [PW-1:0] OUT_MIN = {{(PW-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

    logic                   r_v1, r_v2, r_v3;
    logic [LANES*ACC_W-1:0] r_d1, r_d2;
    logic [LANES*OUT_W-1:0] r_d3;
    logic [LANES-1:0]       r_sat3;

    logic                   w_adv1, w_adv2, w_adv3;
    logic [LANES*ACC_W-1:0] w_act, w_norm;
    logic [LANES*OUT_W-1:0] w_q;
    logic [LANES-1:0]       w_sat;

    // Ready ripples back combinationally so a full pipeline still streams 1 beat/cycle.
    assign w_adv3 = !r_v3 || out_ready;
    assign w_adv2 = !r_v2 || w_adv3;
    assign w_adv1 = !r_v1 || w_adv2;

    assign in_ready    = w_adv1;
    assign out_valid   = r_v3;
    assign ub_data_out = r_d3;
    assign busy        = r_v1 || r_v2 || r_v3;

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        logic signed [ACC_W-1:0] w_x, w_a, w_y1, w_y2, w_y3;
        logic signed [PW-1:0]    w_p, w_sh, w_m, w_b;

        assign w_x  = acc_in[g*ACC_W +: ACC_W];
        assign w_y1 = r_d1[g*ACC_W +: ACC_W];
        assign w_y3 = r_d2[g*ACC_W +: ACC_W];

        always_comb begin
            case (act_mode)
                2'd0:    w_a = w_x;
                2'd1:    w_a = w_x[ACC_W-1] ? '0 : w_x;
                2'd2:    w_a = w_x[ACC_W-1] ? (w_x >>> leaky_shift) : w_x;
                default: begin
                    if (w_x[ACC_W-1])
                        w_a = '0;
                    else if (w_x > act_clip)
                        w_a = act_clip;
                    else
                        w_a = w_x;
                end
            endcase
        end

        always_comb begin
            w_p = PW'(w_y1) * PW'(norm_gain) + PW'(norm_bias);
            if (norm_shift != 5'd0)
                w_p = w_p + (PW'(1) <<< (norm_shift - 5'd1));
            w_sh = w_p >>> norm_shift;
            if (w_sh > ACC_MAX)
                w_y2 = ACC_MAX[ACC_W-1:0];
            else if (w_sh < ACC_MIN)
                w_y2 = ACC_MIN[ACC_W-1:0];
            else
                w_y2 = w_sh[ACC_W-1:0];
        end

        // +128 before the >>>8 rounds the Q8.8 product half up.
        always_comb begin
            w_m = PW'(w_y3) * PW'(q_inv_scale) + PW'(128);
            w_b = (w_m >>> 8) + PW'(q_zero_point);
            w_sat[g] = (w_b > OUT_MAX) || (w_b < OUT_MIN);
            if (w_b > OUT_MAX)
                w_q[g*OUT_W +: OUT_W] = OUT_MAX[OUT_W-1:0];
            else if (w_b < OUT_MIN)
                w_q[g*OUT_W +: OUT_W] = OUT_MIN[OUT_W-1:0];
            else
                w_q[g*OUT_W +: OUT_W] = w_b[OUT_W-1:0];
        end

        assign w_act[g*ACC_W +: ACC_W]  = w_a;
        assign w_norm[g*ACC_W +: ACC_W] = w_y2;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_v1   <= 1'b0;
            r_v2   <= 1'b0;
            r_v3   <= 1'b0;
            r_d1   <= '0;
            r_d2   <= '0;
            r_d3   <= '0;
            r_sat3 <= '0;
        end else begin
            if (w_adv1) begin
                r_v1 <= in_valid;
                if (in_valid)
                    r_d1 <= w_act;
            end
            if (w_adv2) begin
                r_v2 <= r_v1;
                if (r_v1)
                    r_d2 <= w_norm;
            end
            if (w_adv3) begin
                r_v3 <= r_v2;
                if (r_v2) begin
                    r_d3   <= w_q;
                    r_sat3 <= w_sat;
                end
            end
        end
    end

`ifdef ACT_QUANT_SAT_CNT_EN
    localparam int PCW = $clog2(LANES + 1);

    logic [CNT_W-1:0] r_sat_count;
    logic [PCW-1:0]   w_pop;
    logic [CNT_W:0]   w_sum;

    always_comb begin
        w_pop = '0;
        for (int i = 0; i < LANES; i++)
            w_pop = w_pop + PCW'(r_sat3[i]);
        w_sum = {1'b0, r_sat_count} + (CNT_W+1)'(w_pop);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_sat_count <= '0;
        else if (sat_clr)
            r_sat_count <= '0;
        else if (r_v3 && out_ready)
            r_sat_count <= w_sum[CNT_W] ? {CNT_W{1'b1}} : w_sum[CNT_W-1:0];
    end

    assign sat_count = r_sat_count;
`else
    logic w_unused;
    assign w_unused  = ^{sat_clr, r_sat3};
    assign sat_count = '0;
`endif

endmodule

// File: tb/tb_act_quant_pipeline_mlane.sv
// tb/tb_act_quant_pipeline_mlane.sv - self-checking bench for act_quant_pipeline_mlane
module tb_act_quant_pipeline_mlane;
    localparam int LANES = 4;
    localparam int ACC_W = 32;
    localparam int OUT_W = 8;
    localparam int CNT_W = 16;
    localparam int AW = LANES * ACC_W;
    localparam int OW = LANES * OUT_W;

    typedef struct {
        logic [AW-1:0]    acc;
        logic [1:0]       mode;
        logic [2:0]       ls;
        logic [ACC_W-1:0] clip;
    } beat_t;

    logic                    clk = 1'b0;
    logic                    reset;
    logic                    in_valid, in_ready, out_valid, out_ready, busy, sat_clr;
    logic [AW-1:0]           acc_in;
    logic [1:0]              act_mode;
    logic [2:0]              leaky_shift;
    logic [ACC_W-1:0]        act_clip;
    logic signed [15:0]      norm_gain;
    logic signed [31:0]      norm_bias;
    logic [4:0]              norm_shift;
    logic signed [15:0]      q_inv_scale;
    logic signed [OUT_W-1:0] q_zero_point;
    logic [OW-1:0]           ub_data_out;
    logic [CNT_W-1:0]        sat_count;

    int     checks = 0;
    int     failures = 0;
    longint exp_sat = 0;
    beat_t  idle_b;
    beat_t  stim_q[$];
    logic [OW-1:0] obs_q[$];
    int     obs_cyc[$];
    int     acc_cyc[$];
    bit     stream_to;

    always #5 clk = ~clk;

    act_quant_pipeline_mlane #(.LANES(LANES), .ACC_W(ACC_W), .OUT_W(OUT_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .acc_in(acc_in),
        .act_mode(act_mode), .leaky_shift(leaky_shift), .act_clip(act_clip),
        .norm_gain(norm_gain), .norm_bias(norm_bias), .norm_shift(norm_shift),
        .q_inv_scale(q_inv_scale), .q_zero_point(q_zero_point),
        .out_valid(out_valid), .out_ready(out_ready), .ub_data_out(ub_data_out),
        .busy(busy), .sat_clr(sat_clr), .sat_count(sat_count)
    );

    // ---------------- reference model (plain integer arithmetic) ----------------
    function automatic longint fdiv(input longint n, input longint d);
        longint q;
        q = n / d;
        if ((n % d != 0) && (n < 0))
            q = q - 1;
        return q;
    endfunction

    function automatic longint clampl(input longint v, input longint lo, input longint hi);
        if (v < lo) return lo;
        if (v > hi) return hi;
        return v;
    endfunction

    function automatic logic [OW-1:0] model(input beat_t b, output int nsat);
        logic [OW-1:0] r;
        longint x, a, p, y, q, clip;
        longint omax, omin;
        omax = (longint'(1) << (OUT_W - 1)) - 1;
        omin = -(longint'(1) << (OUT_W - 1));
        nsat = 0;
        r = '0;
        clip = longint'($signed(b.clip));
        for (int i = 0; i < LANES; i++) begin
            x = longint'($signed(b.acc[i*ACC_W +: ACC_W]));
            case (b.mode)
                2'd0: a = x;
                2'd1: a = (x < 0) ? 0 : x;
                2'd2: a = (x < 0) ? fdiv(x, longint'(1) << b.ls) : x;
                default: a = (x < 0) ? 0 : ((x > clip) ? clip : x);
            endcase
            p = a * longint'(norm_gain) + longint'(norm_bias);
            if (norm_shift > 0)
                p = fdiv(p + (longint'(1) << (norm_shift - 1)), longint'(1) << norm_shift);
            y = clampl(p, -(longint'(1) << (ACC_W - 1)), (longint'(1) << (ACC_W - 1)) - 1);
            q = fdiv(y * longint'(q_inv_scale) + 128, 256) + longint'(q_zero_point);
            if (q > omax || q < omin)
                nsat++;
            q = clampl(q, omin, omax);
            r[i*OUT_W +: OUT_W] = OUT_W'(q);
        end
        return r;
    endfunction

    task automatic note_sat(input int ns);
`ifdef ACT_QUANT_SAT_CNT_EN
        exp_sat = exp_sat + ns;
        if (exp_sat > (longint'(1) << CNT_W) - 1)
            exp_sat = (longint'(1) << CNT_W) - 1;
`else
        if (ns < 0) exp_sat = 0;
`endif
    endtask

    // ---------------- stimulus helpers (no checking) ----------------
    function automatic beat_t mk_beat(input int l0, input int l1, input int l2, input int l3,
                                      input int mode, input int ls, input int clip);
        beat_t b;
        b.acc[0*ACC_W +: ACC_W] = ACC_W'(l0);
        b.acc[1*ACC_W +: ACC_W] = ACC_W'(l1);
        b.acc[2*ACC_W +: ACC_W] = ACC_W'(l2);
        b.acc[3*ACC_W +: ACC_W] = ACC_W'(l3);
        b.mode = 2'(mode);
        b.ls   = 3'(ls);
        b.clip = ACC_W'(clip);
        return b;
    endfunction

    function automatic beat_t rand_beat();
        beat_t b;
        logic [ACC_W-1:0] w;
        for (int i = 0; i < LANES; i++) begin
            case ($urandom_range(2))
                0: w = $urandom;
                1: w = ACC_W'($urandom_range(600)) - ACC_W'(300);
                default: w = ACC_W'($urandom_range(70000)) - ACC_W'(35000);
            endcase
            b.acc[i*ACC_W +: ACC_W] = w;
        end
        b.mode = 2'($urandom_range(3));
        b.ls   = 3'($urandom_range(7));
        b.clip = ACC_W'($urandom_range(5000));
        return b;
    endfunction

    task automatic set_cfg(input int gain, input int bias, input int sh, input int inv, input int zp);
        norm_gain    = 16'(gain);
        norm_bias    = 32'(bias);
        norm_shift   = 5'(sh);
        q_inv_scale  = 16'(inv);
        q_zero_point = OUT_W'(zp);
    endtask

    // Drive one cycle: inputs applied after the edge, handshakes sampled at the negedge.
    task automatic step(input logic iv, input beat_t b, input logic ordy,
                        output logic acc, output logic got, output logic [OW-1:0] dout);
        in_valid    = iv;
        acc_in      = b.acc;
        act_mode    = b.mode;
        leaky_shift = b.ls;
        act_clip    = b.clip;
        out_ready   = ordy;
        @(negedge clk);
        acc  = in_valid && in_ready;
        got  = out_valid && out_ready;
        dout = ub_data_out;
        @(posedge clk);
        #1;
    endtask

    task automatic run_stream(input int valid_pct, input int ready_pct, input int budget);
        int sent, got;
        logic a, g, iv, rdy;
        logic [OW-1:0] d;
        beat_t b;
        sent = 0;
        got = 0;
        obs_q.delete();
        obs_cyc.delete();
        acc_cyc.delete();
        stream_to = 1'b0;
        for (int c = 0; c < budget && got < stim_q.size(); c++) begin
            iv  = (sent < stim_q.size()) && (int'($urandom_range(99)) < valid_pct);
            if (sent < stim_q.size()) b = stim_q[sent];
            else b = idle_b;
            rdy = int'($urandom_range(99)) < ready_pct;
            step(iv, b, rdy, a, g, d);
            if (a) begin acc_cyc.push_back(c); sent++; end
            if (g) begin obs_q.push_back(d); obs_cyc.push_back(c); got++; end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        if (got < stim_q.size())
            stream_to = 1'b1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        checks++; if (ub_data_out !== '0) begin failures++; $display("FAIL reset_data got=%h exp=0", ub_data_out); end
        checks++; if (sat_count !== '0) begin failures++; $display("FAIL reset_sat_count got=%h exp=0", sat_count); end
    endtask

    task automatic test_basic();
        logic [CNT_W-1:0] es;
        set_cfg(256, 0, 8, 256, 0);
        stim_q.delete();
        stim_q.push_back(mk_beat(5, -3, 200, -200, 0, 0, 0));
        run_stream(100, 100, 20);
        checks++; if (stream_to !== 1'b0) begin failures++; $display("FAIL basic_timeout got=%b exp=0", stream_to); end
        if (obs_q.size() > 0) begin
            checks++; if (obs_q[0] !== 32'h807FFD05) begin failures++; $display("FAIL basic_data got=%h exp=807ffd05", obs_q[0]); end
            checks++; if (obs_cyc[0] - acc_cyc[0] !== 3) begin failures++; $display("FAIL basic_latency got=%0d exp=3", obs_cyc[0] - acc_cyc[0]); end
        end
`ifdef ACT_QUANT_SAT_CNT_EN
        es = 16'd2;
`else
        es = 16'd0;
`endif
        note_sat(2);
        checks++; if (sat_count !== es) begin failures++; $display("FAIL basic_sat_count got=%0d exp=%0d", sat_count, es); end
    endtask

    task automatic test_back_to_back();
        logic [OUT_W-1:0] lane0_exp [4];
        logic [OW-1:0] e;
        int ns;
        lane0_exp[0] = 8'h00; lane0_exp[1] = 8'hFE; lane0_exp[2] = 8'h06; lane0_exp[3] = 8'h00;
        set_cfg(256, 0, 8, 256, 0);
        stim_q.delete();
        stim_q.push_back(mk_beat(-3, int'($urandom_range(200)) - 100, 7, -50, 1, 0, 0));
        stim_q.push_back(mk_beat(-8, int'($urandom_range(200)) - 100, -1, 40, 2, 2, 0));
        stim_q.push_back(mk_beat(10, int'($urandom_range(200)) - 100, 3, -9, 3, 0, 6));
        stim_q.push_back(mk_beat(-4, int'($urandom_range(200)) - 100, 6, 100, 3, 0, 6));
        run_stream(100, 100, 30);
        checks++; if (stream_to !== 1'b0) begin failures++; $display("FAIL b2b_timeout got=%b exp=0", stream_to); end
        for (int i = 0; i < obs_q.size(); i++) begin
            e = model(stim_q[i], ns);
            note_sat(ns);
            checks++; if (obs_q[i][OUT_W-1:0] !== lane0_exp[i]) begin failures++; $display("FAIL b2b_lane0[%0d] got=%h exp=%h", i, obs_q[i][OUT_W-1:0], lane0_exp[i]); end
            checks++; if (obs_q[i] !== e) begin failures++; $display("FAIL b2b_word[%0d] got=%h exp=%h", i, obs_q[i], e); end
            if (i > 0) begin
                checks++; if (obs_cyc[i] - obs_cyc[i-1] !== 1) begin failures++; $display("FAIL b2b_throughput[%0d] gap=%0d exp=1", i, obs_cyc[i] - obs_cyc[i-1]); end
            end
        end
    endtask

    task automatic test_rounding();
        set_cfg(1, 0, 1, 256, 0);
        stim_q.delete();
        stim_q.push_back(mk_beat(3, 0, 0, 0, 0, 0, 0));
        stim_q.push_back(mk_beat(-3, 0, 0, 0, 0, 0, 0));
        run_stream(100, 100, 20);
        checks++; if (obs_q.size() !== 2) begin failures++; $display("FAIL round_count got=%0d exp=2", obs_q.size()); end
        if (obs_q.size() == 2) begin
            checks++; if (obs_q[0] !== 32'h00000002) begin failures++; $display("FAIL round_pos got=%h exp=00000002", obs_q[0]); end
            checks++; if (obs_q[1] !== 32'h000000FF) begin failures++; $display("FAIL round_neg got=%h exp=000000ff", obs_q[1]); end
        end
        set_cfg(1, 0, 1, 128, 0);
        stim_q.delete();
        stim_q.push_back(mk_beat(5, 0, 0, 0, 0, 0, 0));
        run_stream(100, 100, 20);
        if (obs_q.size() > 0) begin
            checks++; if (obs_q[0] !== 32'h00000002) begin failures++; $display("FAIL round_inv128 got=%h exp=00000002", obs_q[0]); end
        end
        set_cfg(1, 0, 1, 256, -10);
        stim_q.delete();
        stim_q.push_back(mk_beat(0, 0, 0, 0, 0, 0, 0));
        run_stream(100, 100, 20);
        if (obs_q.size() > 0) begin
            checks++; if (obs_q[0] !== 32'hF6F6F6F6) begin failures++; $display("FAIL round_zp got=%h exp=f6f6f6f6", obs_q[0]); end
        end
    endtask

    task automatic test_backpressure();
        beat_t bs [5];
        logic a, g;
        logic [OW-1:0] d, e0, e;
        logic [OW-1:0] outs[$];
        int oc[$];
        int sent, ns;
        set_cfg(256, 0, 8, 256, 0);
        for (int i = 0; i < 5; i++) begin
            bs[i] = rand_beat();
            bs[i].mode = 2'd0;
        end
        e0 = model(bs[0], ns);
        sent = 0;
        for (int c = 0; c < 6; c++) begin
            step(sent < 5, bs[(sent < 5) ? sent : 4], 1'b0, a, g, d);
            if (a) sent++;
            if (out_valid) begin
                checks++; if (ub_data_out !== e0) begin failures++; $display("FAIL bp_stall_hold cyc=%0d got=%h exp=%h", c, ub_data_out, e0); end
            end
        end
        checks++; if (sent !== 3) begin failures++; $display("FAIL bp_accepts got=%0d exp=3", sent); end
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_in_ready got=%b exp=0", in_ready); end
        for (int c = 0; c < 20 && outs.size() < 5; c++) begin
            step(sent < 5, bs[(sent < 5) ? sent : 4], 1'b1, a, g, d);
            if (a) sent++;
            if (g) begin outs.push_back(d); oc.push_back(c); end
        end
        in_valid = 1'b0;
        checks++; if (outs.size() !== 5) begin failures++; $display("FAIL bp_count got=%0d exp=5", outs.size()); end
        for (int i = 0; i < outs.size(); i++) begin
            e = model(bs[i], ns);
            note_sat(ns);
            checks++; if (outs[i] !== e) begin failures++; $display("FAIL bp_order[%0d] got=%h exp=%h", i, outs[i], e); end
            checks++; if (oc[i] - oc[0] !== i) begin failures++; $display("FAIL bp_rate[%0d] got=%0d exp=%0d", i, oc[i] - oc[0], i); end
        end
        checks++; if (sat_count !== CNT_W'(exp_sat)) begin failures++; $display("FAIL bp_sat_count got=%0d exp=%0d", sat_count, exp_sat); end
    endtask

    task automatic test_random();
        logic [OW-1:0] e;
        int ns;
        for (int r = 0; r < 4; r++) begin
            set_cfg(int'($urandom_range(1023)) - 512, int'($urandom_range(20000)) - 10000,
                    int'($urandom_range(12)), int'($urandom_range(1023)) - 256, int'($urandom_range(255)));
            if ($urandom_range(3) == 0) norm_gain = 16'($urandom);
            if ($urandom_range(3) == 0) norm_shift = 5'($urandom_range(31));
            stim_q.delete();
            for (int i = 0; i < 30; i++) stim_q.push_back(rand_beat());
            run_stream(70, 60, 400);
            checks++; if (stream_to !== 1'b0) begin failures++; $display("FAIL rand_timeout round=%0d got=%0d exp=30", r, obs_q.size()); end
            for (int i = 0; i < obs_q.size(); i++) begin
                e = model(stim_q[i], ns);
                note_sat(ns);
                checks++; if (obs_q[i] !== e) begin failures++; $display("FAIL rand_word r=%0d i=%0d got=%h exp=%h", r, i, obs_q[i], e); end
            end
            checks++; if (sat_count !== CNT_W'(exp_sat)) begin failures++; $display("FAIL rand_sat_count got=%0d exp=%0d", sat_count, exp_sat); end
        end
    endtask

    task automatic test_reset_midstream();
        logic a, g;
        logic [OW-1:0] d, e;
        int sent, ns;
        set_cfg(256, 0, 8, 256, 0);
        sent = 0;
        for (int c = 0; c < 10 && sent < 3; c++) begin
            step(1'b1, mk_beat(200, 200, -200, 9, 0, 0, 0), 1'b0, a, g, d);
            if (a) sent++;
        end
        checks++; if (sent !== 3) begin failures++; $display("FAIL rst_fill got=%0d exp=3", sent); end
        in_valid = 1'b0;
        reset = 1'b1;
        exp_sat = 0;
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rst_out_valid got=%b exp=0", out_valid); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%b exp=0", busy); end
        checks++; if (ub_data_out !== '0) begin failures++; $display("FAIL rst_data got=%h exp=0", ub_data_out); end
        checks++; if (sat_count !== '0) begin failures++; $display("FAIL rst_sat_count got=%h exp=0", sat_count); end
        @(posedge clk);
        #1;
        reset = 1'b0;
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL rst_in_ready got=%b exp=1", in_ready); end
        stim_q.delete();
        stim_q.push_back(rand_beat());
        run_stream(100, 100, 20);
        checks++; if (obs_q.size() !== 1) begin failures++; $display("FAIL rst_count got=%0d exp=1", obs_q.size()); end
        if (obs_q.size() == 1) begin
            e = model(stim_q[0], ns);
            note_sat(ns);
            checks++; if (obs_q[0] !== e) begin failures++; $display("FAIL rst_word got=%h exp=%h", obs_q[0], e); end
            checks++; if (obs_cyc[0] - acc_cyc[0] !== 3) begin failures++; $display("FAIL rst_latency got=%0d exp=3", obs_cyc[0] - acc_cyc[0]); end
        end
    endtask

`ifdef ACT_QUANT_SAT_CNT_EN
    task automatic test_sat_counter();
        logic a, g;
        logic [OW-1:0] d;
        beat_t b200;
        set_cfg(256, 0, 8, 256, 0);
        b200 = mk_beat(200, 200, 200, 200, 0, 0, 0);
        sat_clr = 1'b1;
        step(1'b0, idle_b, 1'b1, a, g, d);
        sat_clr = 1'b0;
        stim_q.delete();
        for (int i = 0; i < 16383; i++) stim_q.push_back(b200);
        stim_q.push_back(mk_beat(200, -200, 5, 5, 0, 0, 0));
        run_stream(100, 100, 17000);
        checks++; if (stream_to !== 1'b0) begin failures++; $display("FAIL satc_timeout got=%0d exp=16384", obs_q.size()); end
        checks++; if (sat_count !== 16'hFFFE) begin failures++; $display("FAIL satc_fffe got=%h exp=fffe", sat_count); end
        stim_q.delete();
        stim_q.push_back(b200);
        run_stream(100, 100, 20);
        checks++; if (sat_count !== 16'hFFFF) begin failures++; $display("FAIL satc_ceiling got=%h exp=ffff", sat_count); end
        step(1'b1, b200, 1'b0, a, g, d);
        for (int c = 0; c < 10 && !out_valid; c++) step(1'b0, idle_b, 1'b0, a, g, d);
        checks++; if (sat_count !== 16'hFFFF) begin failures++; $display("FAIL satc_hold got=%h exp=ffff", sat_count); end
        sat_clr = 1'b1;
        step(1'b0, idle_b, 1'b1, a, g, d);
        sat_clr = 1'b0;
        checks++; if (g !== 1'b1) begin failures++; $display("FAIL satc_handshake got=%b exp=1", g); end
        checks++; if (sat_count !== 16'h0000) begin failures++; $display("FAIL satc_clr_priority got=%h exp=0000", sat_count); end
        exp_sat = 0;
    endtask
`endif

    initial begin
        idle_b = mk_beat(0, 0, 0, 0, 0, 0, 0);
        reset = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        sat_clr = 1'b0;
        acc_in = '0;
        act_mode = 2'd0;
        leaky_shift = 3'd0;
        act_clip = '0;
        set_cfg(256, 0, 8, 256, 0);
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        test_reset();
        test_basic();
        test_back_to_back();
        test_rounding();
        test_backpressure();
        test_random();
        test_reset_midstream();
`ifdef ACT_QUANT_SAT_CNT_EN
        test_sat_counter();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
